// File: rtl/mure_retire_scheduler.sv
// mure_retire_scheduler: serializes the valid slots of each ingress FIFO head group, in
// ascending port order, onto the single-entry trace pipeline. Tracks pipeline occupancy
// so the last real entry can be pushed through with bubbles once the FIFOs run dry.
module mure_retire_scheduler #(
    parameter int NRET       = 2,
    parameter int PIPE_DEPTH = 3,
    localparam int SEL_W     = (NRET > 1) ? $clog2(NRET) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             empty_i,
    input  logic [NRET-1:0]  slot_valid_i,
    input  logic             ready_i,
    output logic             pop_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             adv_o,
    output logic             entry_valid_o,
    output logic             last_o,
    output logic             busy_o
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic                  r_st;
    logic [NRET-1:0]       r_rem;
    logic [PIPE_DEPTH-1:0] r_occ;

    logic [NRET-1:0]       w_eff;
    logic [NRET-1:0]       w_nxt;
    logic [SEL_W-1:0]      w_low_idx;
    logic                  w_active;
    logic                  w_idle;
    logic                  w_serve;
    logic                  w_null;
    logic                  w_drain;
    logic                  w_adv;
    logic [PIPE_DEPTH-1:0] w_occ_shift;

    // Pending mask: a fresh head group in IDLE, the latched remainder once a group is split.
    always_comb begin
        w_idle = (r_st == ST_IDLE);
        if (w_idle) begin
            w_eff = empty_i ? '0 : slot_valid_i;
        end else begin
            w_eff = r_rem;
        end
        // Clearing the lowest set bit leaves the slots still to be served.
        w_nxt = w_eff & (w_eff - NRET'(1));
    end

    // Lowest set bit of the pending mask; scanning downwards lets the lowest index win.
    always_comb begin
        w_low_idx = '0;
        for (int i = NRET - 1; i >= 0; i--) begin
            if (w_eff[i]) begin
                w_low_idx = SEL_W'(i);
            end
        end
    end

    // Cycle decisions; reset and flush suppress every action.
    always_comb begin
        w_active = !rst_i && !flush_i;
        w_serve  = w_active && ready_i && (|w_eff);
        // A head group with no valid slots is discarded regardless of backpressure.
        w_null   = w_active && w_idle && !empty_i && (slot_valid_i == '0);
        w_drain  = w_active && w_idle && empty_i && (|r_occ) && ready_i;
        w_adv    = w_serve || w_drain;
    end

    // Outputs are purely combinational so serving needs no setup cycle.
    always_comb begin
        pop_o         = (w_serve && (w_nxt == '0)) || w_null;
        adv_o         = w_adv;
        entry_valid_o = w_serve;
        last_o        = w_serve && (w_nxt == '0);
        // Select still tracks the pending slot under backpressure; zero on drain bubbles.
        sel_o         = w_active ? w_low_idx : '0;
        if (rst_i) begin
            busy_o = 1'b0;
        end else if (flush_i) begin
            busy_o = !empty_i;
        end else begin
            busy_o = (r_st == ST_BUSY) || !empty_i || (|r_occ);
        end
    end

    // Occupancy shift value: newest entry enters at bit 0.
    generate
        if (PIPE_DEPTH == 1) begin : g_occ_one
            assign w_occ_shift = w_serve;
        end else begin : g_occ_multi
            assign w_occ_shift = {r_occ[PIPE_DEPTH-2:0], w_serve};
        end
    endgenerate

    // State, remaining-slot mask and pipeline occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_st  <= ST_IDLE;
            r_rem <= '0;
            r_occ <= '0;
        end else begin
            if (w_serve) begin
                if (w_nxt == '0) begin
                    r_st  <= ST_IDLE;
                    r_rem <= '0;
                end else begin
                    r_st  <= ST_BUSY;
                    r_rem <= w_nxt;
                end
            end
            if (w_adv) begin
                r_occ <= w_occ_shift;
            end
        end
    end

endmodule

// File: tb/tb_mure_retire_scheduler.sv
// tb_mure_retire_scheduler: scoreboard bench. The stimulus process drives the ingress FIFO
// view, asks a list-based reference model what the scheduler must do, and queues that
// expectation; a monitor on the falling edge pops and compares against the DUT.
module tb_mure_retire_scheduler;

    localparam int NRET       = 2;
    localparam int PIPE_DEPTH = 3;
    localparam int SEL_W      = (NRET > 1) ? $clog2(NRET) : 1;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             empty_i = 1'b1;
    logic [NRET-1:0]  slot_valid_i = '0;
    logic             ready_i = 1'b0;
    logic             pop_o;
    logic [SEL_W-1:0] sel_o;
    logic             adv_o;
    logic             entry_valid_o;
    logic             last_o;
    logic             busy_o;

    mure_retire_scheduler #(
        .NRET       (NRET),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .empty_i       (empty_i),
        .slot_valid_i  (slot_valid_i),
        .ready_i       (ready_i),
        .pop_o         (pop_o),
        .sel_o         (sel_o),
        .adv_o         (adv_o),
        .entry_valid_o (entry_valid_o),
        .last_o        (last_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic        pop;
        int          sel;
        logic        adv;
        logic        ev;
        logic        last;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Ingress FIFO contents as seen by the scheduler: one mask per group.
    int   fifo[$];

    // Reference model: ports still owed by the current group, and pipeline contents
    // (index 0 = stage nearest the mux).
    int   pend[$];
    int   occ[PIPE_DEPTH];

    function automatic int occ_any();
        int a = 0;
        for (int i = 0; i < PIPE_DEPTH; i++) a |= occ[i];
        return a;
    endfunction

    function automatic void model_clear();
        pend.delete();
        for (int i = 0; i < PIPE_DEPTH; i++) occ[i] = 0;
    endfunction

    // One clock of the scheduler, derived from its rules rather than its encoding.
    function automatic exp_t model_step(logic rst, logic fl, logic emp, int sv, logic rdy);
        exp_t e;
        int   cand[$];
        logic idle;
        e.cyc = cycle; e.pop = 0; e.sel = 0; e.adv = 0; e.ev = 0; e.last = 0; e.busy = 0;
        if (rst) begin
            model_clear();
            return e;
        end
        if (fl) begin
            e.busy = !emp;
            model_clear();
            return e;
        end
        idle = (pend.size() == 0);
        e.busy = !idle || !emp || (occ_any() != 0);
        if (idle) begin
            if (!emp) for (int p = 0; p < NRET; p++) if (sv[p]) cand.push_back(p);
        end else begin
            cand = pend;
        end
        if (cand.size() > 0) e.sel = cand[0];
        if (rdy && cand.size() > 0) begin
            e.adv = 1; e.ev = 1;
            void'(cand.pop_front());
            if (cand.size() == 0) begin
                e.last = 1; e.pop = 1;
            end
            pend = cand;
        end else if (idle && !emp && sv == 0) begin
            e.pop = 1;
        end else if (idle && emp && occ_any() != 0 && rdy) begin
            e.adv = 1;
        end
        if (e.adv) begin
            for (int i = PIPE_DEPTH - 1; i > 0; i--) occ[i] = occ[i-1];
            occ[0] = e.ev;
        end
        return e;
    endfunction

    // Drive one cycle of inputs, queue the expectation, then let the clock edge happen.
    task automatic step(input logic rst, input logic fl, input logic rdy);
        exp_t e;
        int   sv;
        rst_i   = rst;
        flush_i = fl;
        ready_i = rdy;
        empty_i = (fifo.size() == 0);
        sv      = empty_i ? int'($urandom_range(0, (1 << NRET) - 1)) : fifo[0];
        slot_valid_i = NRET'(sv);
        e = model_step(rst, fl, empty_i, sv, rdy);
        sb.push_back(e);
        if (!rst && fl) fifo.delete();
        else if (!rst && e.pop && fifo.size() > 0) void'(fifo.pop_front());
        @(posedge clk_i);
        #1;
        cycle++;
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (pop_o !== e.pop || int'(sel_o) !== e.sel || adv_o !== e.adv ||
                entry_valid_o !== e.ev || last_o !== e.last || busy_o !== e.busy) begin
                errors++;
                $display("FAIL cycle%0d outputs: got pop=%b sel=%0d adv=%b ev=%b last=%b busy=%b, want pop=%b sel=%0d adv=%b ev=%b last=%b busy=%b",
                         e.cyc, pop_o, sel_o, adv_o, entry_valid_o, last_o, busy_o,
                         e.pop, e.sel, e.adv, e.ev, e.last, e.busy);
            end
        end
    end

    initial begin
        model_clear();
        @(posedge clk_i);
        #1;
        // Reset held with a full group waiting: nothing may be popped.
        fifo.push_back(3);
        step(1, 0, 1);
        step(1, 0, 1);
        // Group 11 then 01: three back-to-back advances.
        fifo.push_back(1);
        repeat (3) step(0, 0, 1);
        // Group 10 then empty: serve, three drain bubbles, then idle.
        fifo.push_back(2);
        repeat (6) step(0, 0, 1);
        // Null group under backpressure, then a real group.
        fifo.push_back(0);
        fifo.push_back(1);
        step(0, 0, 0);
        step(0, 0, 1);
        repeat (4) step(0, 0, 1);
        // Group 11 stalled after its first serve.
        fifo.push_back(3);
        step(0, 0, 1);
        repeat (4) step(0, 0, 0);
        step(0, 0, 1);
        repeat (4) step(0, 0, 1);
        // Flush in the middle of a split group, then a fresh group.
        fifo.push_back(3);
        fifo.push_back(3);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        fifo.push_back(2);
        repeat (5) step(0, 0, 1);
        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic r, f, rd;
            if (fifo.size() < 4 && $urandom_range(0, 9) < 4)
                fifo.push_back(int'($urandom_range(0, (1 << NRET) - 1)));
            rd = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 49) == 0);
            r  = ($urandom_range(0, 299) == 0);
            step(r, f, rd);
        end
        fifo.delete();
        repeat (6) step(0, 0, 1);
        @(negedge clk_i);
        #1;
        tests++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
